// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave blocks: FSM encoding,
// synchroniser depth and default geometry.
package spi_pkg;

  localparam int SYNC_STAGES    = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy counter.
// A push while full and a pop while empty are both ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign empty     = (count_r == (ADDR_WIDTH + 1)'(0));
  assign full      = (count_r == FULL_CNT);
  assign do_push_s = wr_en & ~full;
  assign do_pop_s  = rd_en & ~empty;
  assign count     = count_r;
  assign rd_data   = rd_data_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= ADDR_WIDTH'(0);
      rd_ptr_r  <= ADDR_WIDTH'(0);
      count_r   <= (ADDR_WIDTH + 1)'(0);
      rd_data_r <= DATA_WIDTH'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (do_pop_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
        rd_ptr_r  <= rd_ptr_r + ADDR_WIDTH'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples the SPI pins on clk, deserialises
// MSB-first words and queues them in an RX FIFO drained by local logic.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  busy,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [SYNC_STAGES:0]   sclk_sync_r;
  logic [SYNC_STAGES:0]   mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   cs_prev_r;
  logic                   cs_armed_r;
  logic                   sclk_rise_s;
  logic                   mosi_s;
  logic                   cs_n_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;

  state_e                 state_r;
  state_e                 state_nxt;
  logic                   busy_r;
  logic                   frame_err_r;
  logic                   frame_err_nxt;
  logic                   start_s;
  logic                   abort_s;
  logic                   shift_en_s;
  logic                   word_done_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic                   push_r;
  logic [DATA_WIDTH-1:0]  push_data_r;
  logic                   overflow_r;

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_sync_r[SYNC_STAGES];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES];
  assign cs_n_s      = cs_sync_r[SYNC_STAGES-1];
  // A frame may only open once cs_n has been seen high after reset.
  assign cs_fall_s   = cs_prev_r & ~cs_n_s & cs_armed_r;
  assign cs_rise_s   = ~cs_prev_r & cs_n_s;

  // Input synchronisers, sclk edge history and cs_n arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_sync_r   <= '1;
      fill_r      <= '0;
      cs_prev_r   <= 1'b1;
      cs_armed_r  <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-1:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-1:0], mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      fill_r      <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      cs_prev_r   <= cs_n_s;
      cs_armed_r  <= cs_armed_r | (fill_r[SYNC_STAGES-1] & cs_n_s);
    end
  end

  // Frame FSM next-state and control decode
  always_comb begin
    state_nxt     = state_r;
    frame_err_nxt = 1'b0;
    start_s       = 1'b0;
    abort_s       = 1'b0;
    shift_en_s    = 1'b0;
    word_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt = ST_SHIFT;
          start_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt     = ST_IDLE;
          abort_s       = 1'b1;
          frame_err_nxt = (bit_cnt_r != CNT_W'(0));
        end else if (sclk_rise_s) begin
          shift_en_s  = 1'b1;
          word_done_s = (bit_cnt_r == LAST_BIT);
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      busy_r      <= (state_nxt == ST_SHIFT);
      frame_err_r <= frame_err_nxt;
    end
  end

  // Deserialiser; a completed word is handed to the FIFO one clk later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r   <= CNT_W'(0);
      shift_r     <= DATA_WIDTH'(0);
      push_r      <= 1'b0;
      push_data_r <= DATA_WIDTH'(0);
    end else begin
      push_r <= word_done_s;
      if (start_s || abort_s) begin
        bit_cnt_r <= CNT_W'(0);
        shift_r   <= DATA_WIDTH'(0);
      end else if (shift_en_s) begin
        shift_r   <= {shift_r[DATA_WIDTH-2:0], mosi_s};
        bit_cnt_r <= word_done_s ? CNT_W'(0) : bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (word_done_s) begin
        push_data_r <= {shift_r[DATA_WIDTH-2:0], mosi_s};
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (push_r && fifo_full) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_r),
    .wr_data (push_data_r),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign busy      = busy_r;
  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: drives SPI mode-0 frames and compares
// FIFO contents and status against a queue-based model of the receiver.
module tb_spi_slave_rx;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;
  logic       frame_err;

  int errors;
  int checks;
  int ferr_cnt;
  int ferr_long;
  bit ferr_prev;

  logic [7:0] mq[$];
  bit         m_ovf;
  logic [7:0] last_rd;

  spi_slave_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n         (cs_n),
    .busy         (busy),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (frame_err && ferr_prev) ferr_long++;
    ferr_prev = frame_err;
  end

  // Model: a completed word enters the FIFO unless 16 are already held.
  function automatic void model_push(input logic [7:0] w);
    if (mq.size() < 16) mq.push_back(w);
    else m_ovf = 1'b1;
  endfunction

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Sends the top n bits of w MSB-first, 40 ns per sclk phase. With
  // pop_at_push, fifo_rd_en is raised for the clk on which the word is pushed.
  task automatic send_bits(input logic [7:0] w, input int n, input bit pop_at_push);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = w[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == 0 && pop_at_push) begin
        repeat (3) @(negedge clk);
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic pop();
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mq.delete();
    m_ovf   = 1'b0;
    last_rd = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, fifo_empty, fifo_full, fifo_count, overflow, frame_err, fifo_rd_data} !== {1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b empty=%b full=%b count=%0d ovf=%b ferr=%b rd=%h, want 0 1 0 0 0 0 00",
               busy, fifo_empty, fifo_full, fifo_count, overflow, frame_err, fifo_rd_data);
    end
    do_reset();
  endtask

  task automatic test_single();
    cs_low();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    send_bits(8'hA5, 8, 1'b0);
    model_push(8'hA5);
    cs_high();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    checks++;
    if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL single_count: got %0d want %0d", fifo_count, mq.size()); end
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    last_rd = mq.pop_front();
    checks++;
    if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL single_data: got %h want %h", fifo_rd_data, last_rd); end
    checks++;
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = ferr_cnt;
    cs_low();
    send_bits(8'hA5, 8, 1'b0); model_push(8'hA5);
    send_bits(8'h3C, 8, 1'b0); model_push(8'h3C);
    cs_high();
    checks++;
    if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL b2b_count: got %0d want %0d", fifo_count, mq.size()); end
    while (mq.size() > 0) begin
      pop();
      last_rd = mq.pop_front();
      checks++;
      if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL b2b_data: got %h want %h", fifo_rd_data, last_rd); end
    end
    checks++;
    if (ferr_cnt !== f0) begin errors++; $display("FAIL b2b_frame_err: got %0d pulses want 0", ferr_cnt - f0); end
  endtask

  task automatic test_random();
    logic [7:0] w;
    for (int f = 0; f < 4; f++) begin
      cs_low();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        w = 8'($urandom);
        send_bits(w, 8, 1'b0);
        model_push(w);
      end
      cs_high();
      checks++;
      if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL rand_count: got %0d want %0d", fifo_count, mq.size()); end
    end
    while (mq.size() > 0) begin
      pop();
      last_rd = mq.pop_front();
      checks++;
      if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL rand_data: got %h want %h", fifo_rd_data, last_rd); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] w;
    cs_low();
    for (int k = 1; k <= 17; k++) begin
      w = 8'($urandom);
      send_bits(w, 8, 1'b0);
      model_push(w);
      repeat (2) @(negedge clk);
      if (k == 16) begin
        checks++;
        if ({fifo_full, fifo_count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
          errors++; $display("FAIL ovf_full16: got full=%b count=%0d ovf=%b want 1 16 0", fifo_full, fifo_count, overflow);
        end
      end
    end
    cs_high();
    checks++;
    if ({overflow, fifo_count} !== {m_ovf, 5'(mq.size())}) begin
      errors++; $display("FAIL ovf_set: got ovf=%b count=%0d want %b %0d", overflow, fifo_count, m_ovf, mq.size());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    checks++;
    if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_clr: got %b want %b", overflow, m_ovf); end
    while (mq.size() > 0) begin
      pop();
      last_rd = mq.pop_front();
      checks++;
      if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL ovf_data: got %h want %h", fifo_rd_data, last_rd); end
    end
  endtask

  task automatic test_frame_err();
    int f0;
    f0 = ferr_cnt;
    cs_low();
    send_bits(8'($urandom), 5, 1'b0);
    cs_high();
    checks++;
    if ({ferr_cnt - f0, ferr_long, busy, fifo_count} !== {32'd1, 32'd0, 1'b0, 5'(mq.size())}) begin
      errors++; $display("FAIL ferr_partial: got pulses=%0d long=%0d busy=%b count=%0d want 1 0 0 %0d",
                         ferr_cnt - f0, ferr_long, busy, fifo_count, mq.size());
    end
    cs_low();
    send_bits(8'h3C, 8, 1'b0); model_push(8'h3C);
    cs_high();
    pop();
    last_rd = mq.pop_front();
    checks++;
    if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL ferr_recover: got %h want %h", fifo_rd_data, last_rd); end
  endtask

  task automatic test_collision();
    logic [7:0] a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    cs_low(); send_bits(a, 8, 1'b0); cs_high();
    model_push(a);
    // Pop of the older word coincides with the push of b
    cs_low(); send_bits(b, 8, 1'b1); cs_high();
    last_rd = mq.pop_front();
    model_push(b);
    checks++;
    if ({fifo_count, fifo_rd_data} !== {5'(mq.size()), last_rd}) begin
      errors++; $display("FAIL coll_mid: got count=%0d rd=%h want %0d %h", fifo_count, fifo_rd_data, mq.size(), last_rd);
    end
    pop();
    last_rd = mq.pop_front();
    // From empty: the pop is ignored, the push lands
    cs_low(); send_bits(c, 8, 1'b1); cs_high();
    model_push(c);
    checks++;
    if ({fifo_count, fifo_rd_data} !== {5'(mq.size()), last_rd}) begin
      errors++; $display("FAIL coll_empty: got count=%0d rd=%h want %0d %h", fifo_count, fifo_rd_data, mq.size(), last_rd);
    end
    pop();
    last_rd = mq.pop_front();
    checks++;
    if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL coll_drain: got %h want %h", fifo_rd_data, last_rd); end
  endtask

  task automatic test_reset_midframe();
    cs_low();
    send_bits(8'hFF, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, fifo_empty, fifo_count, overflow, frame_err, fifo_rd_data} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rst_mid_outputs: got busy=%b empty=%b count=%0d ovf=%b ferr=%b rd=%h want 0 1 0 0 0 00",
                         busy, fifo_empty, fifo_count, overflow, frame_err, fifo_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    last_rd = 8'h00;
    send_bits(8'h81, 8, 1'b0);
    send_bits(8'h42, 8, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if ({busy, fifo_count} !== {1'b0, 5'd0}) begin
      errors++; $display("FAIL rst_mid_nopush: got busy=%b count=%0d want 0 0", busy, fifo_count);
    end
    cs_high();
    cs_low(); send_bits(8'h5A, 8, 1'b0); model_push(8'h5A); cs_high();
    checks++;
    if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL rst_mid_count: got %0d want %0d", fifo_count, mq.size()); end
    pop();
    last_rd = mq.pop_front();
    checks++;
    if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL rst_mid_data: got %h want %h", fifo_rd_data, last_rd); end
  endtask

  initial begin
    errors = 0; checks = 0; ferr_cnt = 0; ferr_long = 0; ferr_prev = 1'b0;
    m_ovf = 1'b0; last_rd = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
    fifo_rd_en = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_overflow();
    test_frame_err();
    test_collision();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI slave receiver with an RX FIFO; the receiving end of the link driven by spi_master.
- Oversamples sclk/mosi/cs_n on the local system clock and deserialises words MSB-first in SPI mode 0.
- Pushes each completed word into an internal FIFO that local logic drains through a read port.
- Flags overflow and truncated frames.

Parameters:
DATA_WIDTH, 8, bits per SPI word and FIFO entry width
FIFO_DEPTH, 16, RX FIFO entries (power of two)
ADDR_WIDTH, 4, log2(FIFO_DEPTH); FIFO pointer width

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master, asynchronous to clk
mosi  input  1  SPI serial data from master, asynchronous
cs_n  input  1  SPI chip select, active low, asynchronous
busy  output  1  high while a frame is active (synchronised cs_n low)
fifo_rd_en  input  1  pop request from local logic
fifo_rd_data  output  DATA_WIDTH  popped word, registered
fifo_empty  output  1  FIFO holds 0 entries
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a completed word was dropped because the FIFO was full
ovf_clr  input  1  synchronous clear of overflow
frame_err  output  1  one-cycle pulse: cs_n deasserted with a partial word

Behaviour:
- Reset (rst_n low, async): every output goes low except fifo_empty=1. Affected state: pointers, count, shift register, bit counter, synchronisers (cs_n sync chain resets to 1), state=IDLE.
- Synchronisation:
  - sclk, mosi and cs_n each pass through 2 flops.
  - sclk has a 3rd flop for edge detect; mosi is delayed to align with the sclk edge.
  - sclk high and low phases must each be at least 4 clk periods.
  - Input-to-sample latency is 3 clk.
- Mode 0: mosi is sampled on the synchronised sclk rising edge; sclk falling edges are ignored.
- FSM states IDLE and SHIFT:
  - IDLE -> SHIFT on synchronised cs_n falling: bit_cnt=0, shift register cleared, busy=1.
  - SHIFT, each sclk rise: shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s}; bit_cnt++.
  - When bit_cnt==DATA_WIDTH-1 at a rise: the word completes, a push is issued the next clk, and bit_cnt wraps to 0. Back-to-back words need no cs_n toggle.
  - SHIFT -> IDLE on synchronised cs_n rising: busy=0.
  - If bit_cnt!=0 at that point, the partial word is discarded and frame_err pulses 1 cycle.
  - sclk edges while in IDLE are ignored.
- Push:
  - Push when not full: write at wr_ptr, wr_ptr++, count++.
  - Push when full: the word is dropped and overflow=1. This applies even if a pop occurs in the same cycle.
- Pop:
  - fifo_rd_en when not empty: fifo_rd_data <= mem[rd_ptr] on the next edge (1-cycle latency), rd_ptr++, count--.
  - fifo_rd_en when empty: ignored; fifo_rd_data holds its value.
  - Push and pop in the same cycle with FIFO neither full nor empty: count unchanged.
  - Push and pop in the same cycle with FIFO empty: the push succeeds and the pop is ignored.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count, which is registered.
- overflow: set by a dropped push, cleared by ovf_clr. If both occur in the same cycle, set wins.
- Reset mid-frame: everything is cleared. After reset the cs_n sync chain reads high. If the real cs_n is still low, no frame starts until a fresh falling edge is seen.

Decomposition:
- Shared package spi_pkg:
  - state encoding (ST_IDLE, ST_SHIFT)
  - SYNC_STAGES=2
  - default DATA_WIDTH/FIFO_DEPTH/ADDR_WIDTH constants
- One sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH, ADDR_WIDTH), holding the registered-read FIFO with count. The same block serves spi_master's TX FIFO. spi_slave_rx keeps only the synchronisers, the FSM and the shift logic.

Test Plan:
- Reset, then one frame of 0xA5 (sclk period 80 ns, clk 10 ns) -> fifo_count=1; one rd_en -> fifo_rd_data=0xA5 the next cycle, then fifo_empty=1.
- Single cs_n-low frame carrying 0xA5 then 0x3C -> two pushes; pops return 0xA5, 0x3C in order; frame_err never pulses.
- Send 17 words with no reads -> fifo_full=1 after word 16; word 17 dropped; overflow=1 until ovf_clr; first pop returns word 1.
- cs_n rises after 5 bits -> frame_err one-cycle pulse, fifo_count unchanged, busy=0; next full frame 0x3C is received correctly.
- With count=1, pulse rd_en on the exact cycle of a push -> count stays 1, rd_data = older word. Repeat from empty -> count=1, rd_data unchanged.
- Assert rst_n low mid-word with cs_n held low -> outputs at reset values; further sclk edges produce no push until cs_n toggles high then low.
